id_stage_reg: RTL and testbench

ID_STAGE_REG -- requirements
Module: id_stage_reg

---
 rtl/id_stage_reg.sv | 211 +++++++++++++++++++++
 tb/tb_id_stage_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_reg
//  Description : ID-to-EX pipeline register. Captures decoded instruction
//                fields each cycle. Flush inserts a bubble, freeze holds the
//                stored entry, and a saturating counter tracks bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              WB_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EX_command_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              carry_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] PC_out,
  output logic              WB_en_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              B_out,
  output logic              S_out,
  output logic [3:0]        EX_command_out,
  output logic [DATA_W-1:0] Val_Rn_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        Dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              carry_out,
  output logic              ex_busy,
  output logic [7:0]        bubble_cnt_out
);

  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  // Control group
  logic              valid_q,     valid_d;
  logic              wb_en_q,     wb_en_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              b_q,         b_d;
  logic              s_q,         s_d;
  logic [3:0]        ex_cmd_q,    ex_cmd_d;
  // Data group
  logic [DATA_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] val_rn_q,    val_rn_d;
  logic [DATA_W-1:0] val_rm_q,    val_rm_d;
  logic              imm_q,       imm_d;
  logic [11:0]       shift_op_q,  shift_op_d;
  logic [23:0]       simm24_q,    simm24_d;
  logic [3:0]        dest_q,      dest_d;
  logic [3:0]        src1_q,      src1_d;
  logic [3:0]        src2_q,      src2_d;
  logic              carry_q,     carry_d;
  // Bubble statistics
  logic [7:0]        bubble_cnt_q, bubble_cnt_d;

  logic load_en;
  logic load_bubble;

  // Edge qualifiers: flush overrides freeze; an empty slot becomes a bubble
  always_comb begin
    load_en     = flush | ~freeze;
    load_bubble = flush | (~freeze & ~valid_in);
  end

  // Next-state: hold by default, capture when enabled, zero control on bubble
  always_comb begin
    valid_d      = valid_q;
    wb_en_d      = wb_en_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    b_d          = b_q;
    s_d          = s_q;
    ex_cmd_d     = ex_cmd_q;
    pc_d         = pc_q;
    val_rn_d     = val_rn_q;
    val_rm_d     = val_rm_q;
    imm_d        = imm_q;
    shift_op_d   = shift_op_q;
    simm24_d     = simm24_q;
    dest_d       = dest_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    carry_d      = carry_q;
    bubble_cnt_d = bubble_cnt_q;

    if (load_en) begin
      // Data fields are captured even for bubbles so their value stays defined
      pc_d       = PC_in;
      val_rn_d   = Val_Rn_in;
      val_rm_d   = Val_Rm_in;
      imm_d      = imm_in;
      shift_op_d = shift_operand_in;
      simm24_d   = signed_imm_24_in;
      dest_d     = Dest_in;
      src1_d     = src1_in;
      src2_d     = src2_in;
      carry_d    = carry_in;

      if (load_bubble) begin
        valid_d     = 1'b0;
        wb_en_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        b_d         = 1'b0;
        s_d         = 1'b0;
        ex_cmd_d    = 4'b0000;
        if (bubble_cnt_q != C_CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + 8'd1;
        end
      end else begin
        valid_d     = 1'b1;
        wb_en_d     = WB_en_in;
        mem_read_d  = mem_read_in;
        mem_write_d = mem_write_in;
        b_d         = B_in;
        s_d         = S_in;
        ex_cmd_d    = EX_command_in;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      b_q          <= 1'b0;
      s_q          <= 1'b0;
      ex_cmd_q     <= 4'b0000;
      pc_q         <= '0;
      val_rn_q     <= '0;
      val_rm_q     <= '0;
      imm_q        <= 1'b0;
      shift_op_q   <= 12'd0;
      simm24_q     <= 24'd0;
      dest_q       <= 4'd0;
      src1_q       <= 4'd0;
      src2_q       <= 4'd0;
      carry_q      <= 1'b0;
      bubble_cnt_q <= 8'd0;
    end else begin
      valid_q      <= valid_d;
      wb_en_q      <= wb_en_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      b_q          <= b_d;
      s_q          <= s_d;
      ex_cmd_q     <= ex_cmd_d;
      pc_q         <= pc_d;
      val_rn_q     <= val_rn_d;
      val_rm_q     <= val_rm_d;
      imm_q        <= imm_d;
      shift_op_q   <= shift_op_d;
      simm24_q     <= simm24_d;
      dest_q       <= dest_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      carry_q      <= carry_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Outputs come straight from registers; ex_busy is decoded from them only
  always_comb begin
    valid_out         = valid_q;
    PC_out            = pc_q;
    WB_en_out         = wb_en_q;
    mem_read_out      = mem_read_q;
    mem_write_out     = mem_write_q;
    B_out             = b_q;
    S_out             = s_q;
    EX_command_out    = ex_cmd_q;
    Val_Rn_out        = val_rn_q;
    Val_Rm_out        = val_rm_q;
    imm_out           = imm_q;
    shift_operand_out = shift_op_q;
    signed_imm_24_out = simm24_q;
    Dest_out          = dest_q;
    src1_out          = src1_q;
    src2_out          = src2_q;
    carry_out         = carry_q;
    bubble_cnt_out    = bubble_cnt_q;
    ex_busy           = valid_q & (mem_read_q | mem_write_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_reg
//  Description : Directed self-checking bench for the ID-to-EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_id_stage_reg;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, freeze, valid_in;
  logic [DATA_W-1:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic              WB_en_in, mem_read_in, mem_write_in, B_in, S_in;
  logic [3:0]        EX_command_in;
  logic              imm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [3:0]        Dest_in, src1_in, src2_in;
  logic              carry_in;

  logic              valid_out;
  logic [DATA_W-1:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic              WB_en_out, mem_read_out, mem_write_out, B_out, S_out;
  logic [3:0]        EX_command_out;
  logic              imm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm_24_out;
  logic [3:0]        Dest_out, src1_out, src2_out;
  logic              carry_out;
  logic              ex_busy;
  logic [7:0]        bubble_cnt_out;

  int n_cmp = 0;
  int n_err = 0;

  id_stage_reg #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .PC_in(PC_in), .WB_en_in(WB_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .B_in(B_in), .S_in(S_in),
    .EX_command_in(EX_command_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .Dest_in(Dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .carry_in(carry_in),
    .valid_out(valid_out), .PC_out(PC_out), .WB_en_out(WB_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .B_out(B_out),
    .S_out(S_out), .EX_command_out(EX_command_out), .Val_Rn_out(Val_Rn_out),
    .Val_Rm_out(Val_Rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .Dest_out(Dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .carry_out(carry_out), .ex_busy(ex_busy), .bubble_cnt_out(bubble_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},  64'(valid_out), 64'd0);
    check({tag, ".pc"},     64'(PC_out), 64'd0);
    check({tag, ".wb"},     64'(WB_en_out), 64'd0);
    check({tag, ".mrd"},    64'(mem_read_out), 64'd0);
    check({tag, ".mwr"},    64'(mem_write_out), 64'd0);
    check({tag, ".b_s"},    64'({B_out, S_out}), 64'd0);
    check({tag, ".cmd"},    64'(EX_command_out), 64'd0);
    check({tag, ".rn"},     64'(Val_Rn_out), 64'd0);
    check({tag, ".rm"},     64'(Val_Rm_out), 64'd0);
    check({tag, ".misc"},   64'({imm_out, shift_operand_out, signed_imm_24_out}), 64'd0);
    check({tag, ".regs"},   64'({Dest_out, src1_out, src2_out, carry_out}), 64'd0);
    check({tag, ".busy"},   64'(ex_busy), 64'd0);
    check({tag, ".bcnt"},   64'(bubble_cnt_out), 64'd0);
  endtask

  task automatic set_inputs(input logic v, input logic [31:0] pc, input logic wb,
                            input logic mrd, input logic mwr, input logic [3:0] cmd,
                            input logic [31:0] rn, input logic [3:0] dst);
    valid_in = v; PC_in = pc; WB_en_in = wb; mem_read_in = mrd; mem_write_in = mwr;
    EX_command_in = cmd; Val_Rn_in = rn; Dest_in = dst;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    set_inputs(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    B_in = 1'b0; S_in = 1'b0; Val_Rm_in = 32'd0; imm_in = 1'b0;
    shift_operand_in = 12'd0; signed_imm_24_in = 24'd0;
    src1_in = 4'd0; src2_in = 4'd0; carry_in = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // Pass-through of a valid ALU instruction
    set_inputs(1'b1, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h0000_0005, 4'd3);
    Val_Rm_in = 32'h0000_000A; src1_in = 4'd1; src2_in = 4'd2; carry_in = 1'b1;
    shift_operand_in = 12'hABC; signed_imm_24_in = 24'h123456; imm_in = 1'b1;
    B_in = 1'b0; S_in = 1'b1;
    step();
    check("pass.valid", 64'(valid_out), 64'd1);
    check("pass.pc",    64'(PC_out), 64'h1004);
    check("pass.wb",    64'(WB_en_out), 64'd1);
    check("pass.cmd",   64'(EX_command_out), 64'd2);
    check("pass.rn",    64'(Val_Rn_out), 64'd5);
    check("pass.rm",    64'(Val_Rm_out), 64'hA);
    check("pass.dest",  64'(Dest_out), 64'd3);
    check("pass.srcs",  64'({src1_out, src2_out, carry_out}), 64'({4'd1, 4'd2, 1'b1}));
    check("pass.misc",  64'({imm_out, shift_operand_out, signed_imm_24_out}),
                        64'({1'b1, 12'hABC, 24'h123456}));
    check("pass.s",     64'({B_out, S_out}), 64'b01);
    check("pass.busy",  64'(ex_busy), 64'd0);
    check("pass.bcnt",  64'(bubble_cnt_out), 64'd0);

    // Invalid slot: control bits are dropped, counted as a bubble
    set_inputs(1'b0, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h77, 4'd9);
    step();
    check("inv.valid", 64'(valid_out), 64'd0);
    check("inv.mwr",   64'(mem_write_out), 64'd0);
    check("inv.wb",    64'(WB_en_out), 64'd0);
    check("inv.cmd",   64'(EX_command_out), 64'd0);
    check("inv.busy",  64'(ex_busy), 64'd0);
    check("inv.pc",    64'(PC_out), 64'h2000);
    check("inv.bcnt",  64'(bubble_cnt_out), 64'd1);

    // Load a memory read, then freeze for three cycles with changing inputs
    set_inputs(1'b1, 32'h0000_3008, 1'b1, 1'b1, 1'b0, 4'b0010, 32'h100, 4'd7);
    step();
    check("ld.busy", 64'(ex_busy), 64'd1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(i[0], 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b1, 4'(i + 5), 32'(i), 4'(i));
      step();
      check("frz.pc",    64'(PC_out), 64'h3008);
      check("frz.valid", 64'(valid_out), 64'd1);
      check("frz.mrd",   64'(mem_read_out), 64'd1);
      check("frz.rn",    64'(Val_Rn_out), 64'h100);
      check("frz.busy",  64'(ex_busy), 64'd1);
      check("frz.bcnt",  64'(bubble_cnt_out), 64'd1);
    end

    // Flush and freeze together: flush wins, bubble is inserted
    flush = 1'b1;
    set_inputs(1'b1, 32'h0000_5004, 1'b1, 1'b0, 1'b0, 4'b1001, 32'h55, 4'd4);
    step();
    check("flfr.valid", 64'(valid_out), 64'd0);
    check("flfr.wb",    64'(WB_en_out), 64'd0);
    check("flfr.cmd",   64'(EX_command_out), 64'd0);
    check("flfr.pc",    64'(PC_out), 64'h5004);
    check("flfr.bcnt",  64'(bubble_cnt_out), 64'd2);
    flush = 1'b0; freeze = 1'b0;

    // Capture an entry, then reset asynchronously mid-cycle while frozen
    set_inputs(1'b1, 32'h0000_6004, 1'b1, 1'b0, 1'b1, 4'b1111, 32'hFFFF_FFFF, 4'd15);
    step();
    check("pre.busy", 64'(ex_busy), 64'd1);
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    #3 rst = 1'b0;
    step();
    check("frz0.valid", 64'(valid_out), 64'd0);
    check("frz0.pc",    64'(PC_out), 64'd0);
    check("frz0.cmd",   64'(EX_command_out), 64'd0);
    check("frz0.bcnt",  64'(bubble_cnt_out), 64'd0);
    freeze = 1'b0;

    // Saturation of the bubble counter under continuous flush
    flush = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) check("sat.254", 64'(bubble_cnt_out), 64'd254);
      if (i == 255) check("sat.255", 64'(bubble_cnt_out), 64'd255);
    end
    check("sat.300",   64'(bubble_cnt_out), 64'd255);
    check("sat.valid", 64'(valid_out), 64'd0);
    flush = 1'b0;
    step();
    check("sat.hold",  64'(bubble_cnt_out), 64'd255);
    check("sat.cap",   64'(valid_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
